main_memory_arbiter: RTL

//  Shares the single main memory controller port between the instruction cache controller (I, read-only)
//  and the data cache controller (D, read/write), whole-block transfers only. One transaction in flight;

---
 rtl/main_memory_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: round-robin sharing of one main memory port between the I and D cache controllers, with watchdog abort
module main_memory_arbiter #(
  parameter int ADRES_BIT   = 32,
  parameter int BLOK_BIT    = 128,
  parameter int ZAMAN_ASIMI = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADRES_BIT-1:0] b_okuma_istek_adres_i,
  input  logic                 b_okuma_istek_gecerli_i,
  output logic [BLOK_BIT-1:0]  b_okuma_veri_blok_o,
  output logic                 b_okuma_istek_hazir_o,
  input  logic [ADRES_BIT-1:0] v_istek_adres_i,
  input  logic                 v_istek_gecerli_i,
  input  logic                 v_istek_yaz_i,
  input  logic [BLOK_BIT-1:0]  v_yazma_veri_blok_i,
  output logic [BLOK_BIT-1:0]  v_okuma_veri_blok_o,
  output logic                 v_istek_hazir_o,
  output logic [ADRES_BIT-1:0] anabellek_istek_adres_o,
  output logic                 anabellek_istek_gecerli_o,
  output logic                 anabellek_istek_yaz_o,
  output logic [BLOK_BIT-1:0]  anabellek_yazma_veri_blok_o,
  input  logic [BLOK_BIT-1:0]  anabellek_okuma_veri_blok_i,
  input  logic                 anabellek_istek_hazir_i,
  output logic                 zaman_asimi_o
);
  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] ISTEK = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;

  logic [1:0]           state;
  logic                 owner;
  logic                 son_hibe;
  logic                 yaz_q;
  logic                 abort_q;
  logic [9:0]           cnt;
  logic [ADRES_BIT-1:0] addr_q;
  logic [BLOK_BIT-1:0]  wdata_q;
  logic                 grant_i;
  logic                 grant_d;
  logic                 timeout;
  logic [ADRES_BIT-1:0] sel_addr;

  // Arbitration: on a tie the requester that was not served last wins (owner/son_hibe: 1 = D)
  always_comb begin
    grant_d  = v_istek_gecerli_i && (!b_okuma_istek_gecerli_i || !son_hibe);
    grant_i  = b_okuma_istek_gecerli_i && !grant_d;
    sel_addr = grant_d ? v_istek_adres_i : b_okuma_istek_adres_i;
    timeout  = cnt == 10'(ZAMAN_ASIMI - 1);
  end

  // Transaction FSM: capture the winner in BOSTA, hold the memory request in ISTEK, report in YANIT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= BOSTA;
      owner               <= 1'b0;
      son_hibe            <= 1'b1;
      yaz_q               <= 1'b0;
      abort_q             <= 1'b0;
      cnt                 <= '0;
      addr_q              <= '0;
      wdata_q             <= '0;
      b_okuma_veri_blok_o <= '0;
      v_okuma_veri_blok_o <= '0;
    end else begin
      case (state)
        BOSTA: begin
          if (grant_i || grant_d) begin
            owner   <= grant_d;
            addr_q  <= sel_addr & ~ADRES_BIT'(15);
            yaz_q   <= grant_d && v_istek_yaz_i;
            wdata_q <= grant_d ? v_yazma_veri_blok_i : '0;
            cnt     <= '0;
            abort_q <= 1'b0;
            state   <= ISTEK;
          end
        end
        ISTEK: begin
          if (anabellek_istek_hazir_i) begin
            son_hibe <= owner;
            if (!yaz_q && !owner) b_okuma_veri_blok_o <= anabellek_okuma_veri_blok_i;
            if (!yaz_q && owner)  v_okuma_veri_blok_o <= anabellek_okuma_veri_blok_i;
            state <= YANIT;
          end else if (timeout) begin
            son_hibe <= owner;
            abort_q  <= 1'b1;
            if (!owner) b_okuma_veri_blok_o <= '0;
            if (owner)  v_okuma_veri_blok_o <= '0;
            state <= YANIT;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        YANIT: begin
          cnt     <= '0;
          abort_q <= 1'b0;
          state   <= BOSTA;
        end
        default: state <= BOSTA;
      endcase
    end
  end

  // Outputs decoded from state so an async reset clears them immediately
  always_comb begin
    anabellek_istek_gecerli_o   = state == ISTEK;
    anabellek_istek_adres_o     = anabellek_istek_gecerli_o ? addr_q : '0;
    anabellek_istek_yaz_o       = anabellek_istek_gecerli_o && yaz_q;
    anabellek_yazma_veri_blok_o = anabellek_istek_gecerli_o ? wdata_q : '0;
    b_okuma_istek_hazir_o       = state == YANIT && !owner;
    v_istek_hazir_o             = state == YANIT && owner;
    zaman_asimi_o               = state == YANIT && abort_q;
  end
endmodule
